// File: rtl/fetch_pkg.sv
// Shared ICCM geometry and instruction-buffer entry layout for the fetch path.
package fetch_pkg;

   localparam int ICCM_ADDR_WIDTH      = 11;
   localparam int ICCM_DATA_WIDTH      = 32;
   localparam int ICCM_DEPTH           = 2048;
   localparam int IBUF_DEPTH           = 4;
   localparam int IBUF_MAX_OUTSTANDING = 2;

   // Buffer entry: PC in the upper bits, instruction in the lower bits.
   typedef struct packed {
      logic [ICCM_ADDR_WIDTH-1:0] pc;
      logic [ICCM_DATA_WIDTH-1:0] instr;
   } ibuf_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a synchronous clear.
module sync_fifo
   import fetch_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push_s, do_pop_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         return '0;
      end else begin
         return ptr + PTR_W'(1);
      end
   endfunction

   assign do_push_s = push_i & (count_q != CNT_W'(DEPTH));
   assign do_pop_s  = pop_i & (count_q != CNT_W'(0));

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy alone qualifies the head.
   always_ff @(posedge clk) begin
      if (do_push_s && !clr_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_ibuf.sv
// Instruction fetch buffer: credit-based ICCM read issue, PC tagging of
// responses, flush-time discard of in-flight reads and a FWFT decoder queue.
module fetch_ibuf
   import fetch_pkg::*;
#(
   parameter  int ADDR_WIDTH      = ICCM_ADDR_WIDTH,
   parameter  int DATA_WIDTH      = ICCM_DATA_WIDTH,
   parameter  int DEPTH           = IBUF_DEPTH,
   parameter  int MAX_OUTSTANDING = IBUF_MAX_OUTSTANDING,
   localparam int CNT_W           = $clog2(DEPTH) + 1,
   localparam int OUT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  bist_en,
   output logic                  fetch_rd,
   input  logic [ADDR_WIDTH-1:0] fetch_pc,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_valid,
   output logic                  dec_valid,
   input  logic                  dec_ready,
   output logic [DATA_WIDTH-1:0] dec_instr,
   output logic [ADDR_WIDTH-1:0] dec_pc,
   output logic [CNT_W-1:0]      buf_count,
   output logic                  proto_err
);

   localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
   localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

   logic [OUT_W-1:0]      outstanding_s;
   logic [OUT_W-1:0]      drop_cnt_q, drop_cnt_d;
   logic                  proto_err_q, proto_err_d;
   logic [SUM_W-1:0]      occupancy_s;
   logic                  credit_ok_s, issue_s;
   logic                  rsp_valid_s, rsp_accept_s;
   logic                  buf_push_s, buf_pop_s;
   logic [ADDR_WIDTH-1:0] tag_s;
   logic [ENT_W-1:0]      head_s;

   // Buffer slots already promised to in-flight reads count against the credit.
   assign occupancy_s  = SUM_W'(buf_count) + SUM_W'(outstanding_s);
   assign credit_ok_s  = (occupancy_s < SUM_W'(DEPTH)) &&
                         (outstanding_s < OUT_W'(MAX_OUTSTANDING));
   assign issue_s      = rst_n & ~flush & ~bist_en & credit_ok_s;
   assign rsp_valid_s  = rd_valid & ~bist_en;
   assign rsp_accept_s = rsp_valid_s & (outstanding_s != OUT_W'(0));
   assign buf_push_s   = rsp_accept_s & (drop_cnt_q == OUT_W'(0)) & ~flush;
   assign buf_pop_s    = dec_valid & dec_ready & ~flush;

   always_comb begin
      drop_cnt_d  = drop_cnt_q;
      proto_err_d = proto_err_q;
      if (flush) begin
         drop_cnt_d = outstanding_s - OUT_W'(rsp_accept_s);
      end else if (rsp_accept_s && (drop_cnt_q != OUT_W'(0))) begin
         drop_cnt_d = drop_cnt_q - OUT_W'(1);
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
      if (rsp_valid_s && (outstanding_s == OUT_W'(0))) begin
         proto_err_d = 1'b1;
      end else begin
         proto_err_d = proto_err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         drop_cnt_q  <= drop_cnt_d;
         proto_err_q <= proto_err_d;
      end
   end

   sync_fifo #(
      .WIDTH(ADDR_WIDTH),
      .DEPTH(MAX_OUTSTANDING)
   ) u_tag_q (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (1'b0),
      .push_i (issue_s),
      .wdata_i(fetch_pc),
      .pop_i  (rsp_accept_s),
      .rdata_o(tag_s),
      .count_o(outstanding_s)
   );

   sync_fifo #(
      .WIDTH(ENT_W),
      .DEPTH(DEPTH)
   ) u_ibuf (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (flush),
      .push_i (buf_push_s),
      .wdata_i({tag_s, rd_data}),
      .pop_i  (buf_pop_s),
      .rdata_o(head_s),
      .count_o(buf_count)
   );

   assign fetch_rd  = issue_s;
   assign dec_valid = (buf_count != CNT_W'(0));
   assign dec_pc    = head_s[ENT_W-1:DATA_WIDTH];
   assign dec_instr = head_s[DATA_WIDTH-1:0];
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_fetch_ibuf.sv
// Directed bench for fetch_ibuf with a behavioural ICCM controller model.
module tb_fetch_ibuf;

   localparam int AW = 11;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n, flush, bist_en, fetch_rd, rd_valid, dec_valid, dec_ready, proto_err;
   logic [AW-1:0] fetch_pc, dec_pc, pc_ctr;
   logic [DW-1:0] rd_data, dec_instr;
   logic [2:0]    buf_count;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            lat = 1;
   int            force_rv = 0;
   int            issues = 0;
   int            rd_high = 0;
   int            max_out = 0;
   logic [AW-1:0] pend_pc[$];
   int            pend_due[$];
   logic [AW-1:0] obs_pc[$];
   logic [DW-1:0] obs_instr[$];

   always #5 clk = ~clk;

   fetch_ibuf dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bist_en(bist_en),
      .fetch_rd(fetch_rd), .fetch_pc(fetch_pc), .rd_data(rd_data), .rd_valid(rd_valid),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
      .buf_count(buf_count), .proto_err(proto_err)
   );

   // One clock of stimulus: controller responses, request capture, decoder capture.
   task automatic cycle();
      rd_valid = 1'b0;
      rd_data  = 32'h0000_0000;
      if (force_rv == 2) begin
         rd_valid = 1'b1;
         rd_data  = 32'hDEAD_BEEF;
      end else if (force_rv == 1) begin
         rd_valid = 1'($urandom_range(0, 1));
         rd_data  = $urandom;
      end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
         rd_valid = 1'b1;
         rd_data  = 32'h1000_0000 + 32'(pend_pc[0]);
         void'(pend_pc.pop_front());
         void'(pend_due.pop_front());
      end
      fetch_pc = pc_ctr;
      #1;
      if (fetch_rd === 1'b1) begin
         pend_pc.push_back(pc_ctr);
         pend_due.push_back(cyc + lat);
         pc_ctr = pc_ctr + 11'd1;
         issues++;
         rd_high++;
         if (pend_pc.size() > max_out) max_out = pend_pc.size();
      end
      if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
         obs_pc.push_back(dec_pc);
         obs_instr.push_back(dec_instr);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      pend_pc.delete();
      pend_due.delete();
      rst_n = 1'b0; flush = 1'b0; bist_en = 1'b0; force_rv = 0;
      cycle();
      cycle();
      rst_n = 1'b1;
      obs_pc.delete();
      obs_instr.delete();
      issues = 0; rd_high = 0; max_out = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; bist_en = 1'b0; dec_ready = 1'b0; pc_ctr = 11'h000;
      @(posedge clk); #1;
      cycle();
      checks++; if (fetch_rd !== 1'b0) begin errors++; $display("FAIL reset_fetch_rd: got %b expected 0", fetch_rd); end
      checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", buf_count); end
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
      do_reset();
   endtask

   task automatic test_streaming();
      do_reset();
      lat = 1; dec_ready = 1'b1; pc_ctr = 11'h000;
      for (int i = 0; i < 16; i++) cycle();
      checks++; if (rd_high !== 16) begin errors++; $display("FAIL stream_fetch_rd_high: got %0d expected 16", rd_high); end
      for (int i = 0; i < 6; i++) cycle();
      checks++; if (max_out > 2) begin errors++; $display("FAIL stream_outstanding: got %0d expected <=2", max_out); end
      checks++;
      if (obs_pc.size() < 16) begin
         errors++; $display("FAIL stream_out_count: got %0d expected >=16", obs_pc.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++; if (obs_pc[i] !== 11'(i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, obs_pc[i], 11'(i)); end
            checks++; if (obs_instr[i] !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, obs_instr[i], 32'h1000_0000 + 32'(i)); end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      lat = 1; dec_ready = 1'b0; pc_ctr = 11'h000;
      for (int i = 0; i < 10; i++) cycle();
      checks++; if (issues !== 4) begin errors++; $display("FAIL bp_issues: got %0d expected 4", issues); end
      checks++; if (fetch_rd !== 1'b0) begin errors++; $display("FAIL bp_fetch_rd_full: got %b expected 0", fetch_rd); end
      checks++; if (buf_count !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", buf_count); end
      dec_ready = 1'b1;
      #1;
      checks++; if (dec_pc !== 11'h000) begin errors++; $display("FAIL bp_head_pc: got %h expected 000", dec_pc); end
      checks++; if (dec_instr !== 32'h1000_0000) begin errors++; $display("FAIL bp_head_instr: got %h expected 10000000", dec_instr); end
      checks++; if (fetch_rd !== 1'b0) begin errors++; $display("FAIL bp_no_issue_pop_cycle: got %b expected 0", fetch_rd); end
      cycle();
      checks++; if (fetch_rd !== 1'b1) begin errors++; $display("FAIL bp_issue_resumes: got %b expected 1", fetch_rd); end
   endtask

   task automatic test_flush_inflight();
      do_reset();
      lat = 2; dec_ready = 1'b0; pc_ctr = 11'h0F0;
      for (int i = 0; i < 5; i++) cycle();
      checks++; if (buf_count !== 3'd2) begin errors++; $display("FAIL fl_pre_count: got %0d expected 2", buf_count); end
      flush = 1'b1; pc_ctr = 11'h100;
      cycle();
      flush = 1'b0;
      checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL fl_count: got %0d expected 0", buf_count); end
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL fl_dec_valid: got %b expected 0", dec_valid); end
      checks++; if (dut.drop_cnt_q !== 2'd1) begin errors++; $display("FAIL fl_drop_cnt: got %0d expected 1", dut.drop_cnt_q); end
      dec_ready = 1'b1;
      obs_pc.delete(); obs_instr.delete();
      for (int i = 0; i < 6; i++) cycle();
      checks++;
      if (obs_pc.size() == 0) begin
         errors++; $display("FAIL fl_output: got 0 outputs expected >=1");
      end else begin
         checks++; if (obs_pc[0] !== 11'h100) begin errors++; $display("FAIL fl_first_pc: got %h expected 100", obs_pc[0]); end
         checks++; if (obs_instr[0] !== 32'h1000_0100) begin errors++; $display("FAIL fl_first_instr: got %h expected 10000100", obs_instr[0]); end
      end
   endtask

   task automatic test_flush_with_rsp();
      do_reset();
      lat = 1; dec_ready = 1'b1; pc_ctr = 11'h050;
      cycle();
      flush = 1'b1; pc_ctr = 11'h200;
      cycle();
      flush = 1'b0;
      checks++; if (dut.drop_cnt_q !== 2'd0) begin errors++; $display("FAIL fr_drop_cnt: got %0d expected 0", dut.drop_cnt_q); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL fr_proto_err: got %b expected 0", proto_err); end
      checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL fr_count: got %0d expected 0", buf_count); end
      obs_pc.delete(); obs_instr.delete();
      for (int i = 0; i < 4; i++) cycle();
      checks++;
      if (obs_pc.size() == 0) begin
         errors++; $display("FAIL fr_output: got 0 outputs expected >=1");
      end else begin
         checks++; if (obs_pc[0] !== 11'h200) begin errors++; $display("FAIL fr_first_pc: got %h expected 200", obs_pc[0]); end
      end
   endtask

   task automatic test_bist();
      do_reset();
      lat = 1; dec_ready = 1'b0; pc_ctr = 11'h000;
      for (int i = 0; i < 8; i++) cycle();
      checks++; if (buf_count !== 3'd4) begin errors++; $display("FAIL bist_pre_count: got %0d expected 4", buf_count); end
      bist_en = 1'b1; force_rv = 1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         checks++; if (fetch_rd !== 1'b0) begin errors++; $display("FAIL bist_fetch_rd[%0d]: got %b expected 0", i, fetch_rd); end
      end
      checks++; if (buf_count !== 3'd4) begin errors++; $display("FAIL bist_count: got %0d expected 4", buf_count); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL bist_proto_err: got %b expected 0", proto_err); end
      checks++; if (dec_pc !== 11'h000) begin errors++; $display("FAIL bist_head_pc: got %h expected 000", dec_pc); end
      bist_en = 1'b0; force_rv = 0; dec_ready = 1'b1;
      obs_pc.delete(); obs_instr.delete();
      cycle();
      checks++; if (fetch_rd !== 1'b1) begin errors++; $display("FAIL bist_resume: got %b expected 1", fetch_rd); end
      for (int i = 0; i < 8; i++) cycle();
      checks++;
      if (obs_pc.size() < 5) begin
         errors++; $display("FAIL bist_out_count: got %0d expected >=5", obs_pc.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++; if (obs_pc[i] !== 11'(i)) begin errors++; $display("FAIL bist_pc[%0d]: got %h expected %h", i, obs_pc[i], 11'(i)); end
         end
      end
   endtask

   task automatic test_proto_err_reset();
      do_reset();
      lat = 1; dec_ready = 1'b0; pc_ctr = 11'h000;
      force_rv = 2;
      cycle();
      force_rv = 0;
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pe_set: got %b expected 1", proto_err); end
      for (int i = 0; i < 8; i++) cycle();
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pe_sticky: got %b expected 1", proto_err); end
      checks++; if (buf_count !== 3'd4) begin errors++; $display("FAIL pe_fill: got %0d expected 4", buf_count); end
      rst_n = 1'b0;
      #1;
      checks++; if (fetch_rd !== 1'b0) begin errors++; $display("FAIL pe_rst_fetch_rd: got %b expected 0", fetch_rd); end
      pend_pc.delete(); pend_due.delete();
      cycle();
      rst_n = 1'b1;
      #1;
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL pe_rst_proto: got %b expected 0", proto_err); end
      checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL pe_rst_count: got %0d expected 0", buf_count); end
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL pe_rst_dec_valid: got %b expected 0", dec_valid); end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; bist_en = 1'b0; dec_ready = 1'b0;
      rd_valid = 1'b0; rd_data = 32'h0000_0000; fetch_pc = 11'h000; pc_ctr = 11'h000;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush_inflight();
      test_flush_with_rsp();
      test_bist();
      test_proto_err_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_ibuf.md
Name: fetch_ibuf

Overview:
- Instruction fetch buffer, directly downstream of the fetch interface (PC block + ICCM controller). It issues ICCM read requests using a credit scheme, pairs each returned word with its PC, and queues {pc, instr} pairs for the decoder over a valid/ready handshake.
- Handles pipeline flush on redirect by discarding in-flight responses.
- Yields to BIST when bist_en is high.

Parameters:
ADDR_WIDTH, 11, ICCM word-address / PC width
DATA_WIDTH, 32, instruction width
DEPTH, 4, instruction buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum in-flight ICCM reads (power of 2, >=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  redirect; drop buffered and in-flight instructions
bist_en  in  1  BIST owns ICCM; no requests, responses ignored
fetch_rd  out  1  read request to fetch interface (cntlr_rd); also PC advance
fetch_pc  in  ADDR_WIDTH  PC presented with the request in the same cycle
rd_data  in  DATA_WIDTH  ICCM read data
rd_valid  in  1  read data valid, one pulse per request, in order
dec_valid  out  1  head entry valid
dec_ready  in  1  decoder accepts head
dec_instr  out  DATA_WIDTH  head instruction
dec_pc  out  ADDR_WIDTH  head PC
buf_count  out  $clog2(DEPTH)+1  occupied entries
proto_err  out  1  sticky: rd_valid seen with nothing outstanding

Behaviour:
- Reset (rst_n low at posedge): count=0, outstanding=0, drop_cnt=0, pointers=0, proto_err=0. fetch_rd is forced to 0 combinationally while rst_n is low. dec_valid=0; dec_instr and dec_pc are don't-care.
- Issue: fetch_rd = rst_n & !flush & !bist_en & (count+outstanding < DEPTH) & (outstanding < MAX_OUTSTANDING).
  - On issue, fetch_pc is pushed into the tag queue (depth MAX_OUTSTANDING).
  - Credits guarantee the buffer never overflows.
- Response: every rd_valid with outstanding>0 pops the tag queue and decrements outstanding.
  - If drop_cnt>0: data is discarded and drop_cnt decrements.
  - Otherwise {tag, rd_data} is written to the buffer tail.
- rd_valid with outstanding==0: ignored, proto_err<=1 (held until reset).
- bist_en high: no issue; rd_valid is ignored entirely (no pop, no count change); buffered contents are held. bist_en has no effect on proto_err.
- Output: first-word-fall-through. dec_valid = (count!=0); dec_instr and dec_pc come from the head entry. Pop occurs on dec_valid & dec_ready.
- Latency: rd_valid in cycle N gives dec_valid in cycle N+1 (empty buffer). Issue-to-output latency = controller latency + 1.
- Simultaneous push and pop: both occur; count is unchanged.
- Full buffer with dec_ready low: no issue; occupancy is held.
- Flush (highest priority):
  - Next cycle count=0 and head=tail.
  - drop_cnt <= outstanding - (rd_valid?1:0); outstanding updates normally.
  - A response arriving in the flush cycle is discarded.
  - A dec pop in the flush cycle is irrelevant.
  - No issue in the flush cycle.
- Flush while drop_cnt>0: drop_cnt is recomputed from outstanding as above. It never exceeds outstanding.
- Pointers wrap modulo DEPTH and MAX_OUTSTANDING. count, outstanding and drop_cnt use widths of $clog2(N)+1.
- Reset mid-operation: all in-flight state is cleared. A late rd_valid after reset sets proto_err; the system holds the ICCM controller in reset together with this block.

Decomposition:
- Shared package/header fetch_pkg: ICCM ADDR_WIDTH/DATA_WIDTH defaults, ICCM depth 2048, buffer entry layout {pc, instr}.
- One sub-module, sync_fifo (parameterised WIDTH/DEPTH, FWFT, clear input). It is instantiated twice:
  - instruction buffer, WIDTH=ADDR_WIDTH+DATA_WIDTH, DEPTH;
  - PC tag queue, WIDTH=ADDR_WIDTH, MAX_OUTSTANDING.
- Credit, drop and error logic lives in fetch_ibuf.

Test Plan:
- Streaming: controller model with 1-cycle latency, dec_ready=1, PCs 0x000..0x00F, data 0x1000_0000+pc. Required: 16 in-order outputs with matching pc/instr, and fetch_rd held high with outstanding<=2.
- Backpressure: dec_ready=0 after reset. Required: exactly 4 issues, then fetch_rd=0, buf_count=4. Raise dec_ready: the head is pc 0x000, and issue resumes the cycle after the first pop.
- Flush in flight: 2-cycle latency, 2 outstanding, assert flush for 1 cycle. Required: the next cycle has buf_count=0 and dec_valid=0; both late responses are dropped; the first post-flush PC 0x100 is the next dec_pc.
- Flush coinciding with rd_valid: 1 outstanding, flush and rd_valid in the same cycle. Required: data discarded, drop_cnt=0, no proto_err.
- BIST: bist_en=1 for 10 cycles with random rd_valid pulses. Required: fetch_rd=0, buffer unchanged, proto_err=0; normal fetch resumes after bist_en falls.
- Protocol error and reset: rd_valid with nothing outstanding sets proto_err=1, and it stays high. Synchronous rst_n low for 1 cycle: proto_err=0, buf_count=0, dec_valid=0.
